// File: rtl/modbus_rtu_pkg.sv
// Shared types, constants and timing helpers for the Modbus RTU frame receiver.
package modbus_rtu_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RECV  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4
  } rx_state_e;

  localparam int ERR_CRC   = 0;
  localparam int ERR_SHORT = 1;
  localparam int ERR_OVF   = 2;
  localparam int ERR_GAP   = 3;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // Above 19200 baud the Modbus inter-character times are fixed at 750 us / 1750 us.
  function automatic int calc_t15(input longint clk_freq, input longint baud_rate);
    if (baud_rate > 19200) return int'(clk_freq * 750 / 1000000);
    return int'(clk_freq * 33 / (2 * baud_rate));
  endfunction

  function automatic int calc_t35(input longint clk_freq, input longint baud_rate);
    if (baud_rate > 19200) return int'(clk_freq * 1750 / 1000000);
    return int'(clk_freq * 77 / (2 * baud_rate));
  endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// Bit-serial Modbus CRC-16: one byte absorbed per start pulse, eight cycles per byte.
module modbus_crc16_byte
  import modbus_rtu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        busy,
  output logic [15:0] crc
);

  logic [7:0] shift_q;
  logic [3:0] bit_cnt;
  logic       feedback;

  assign feedback = crc[0] ^ shift_q[0];
  assign busy     = (bit_cnt != 4'd0);

  // clear together with start seeds the register before the first bit is processed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      crc     <= CRC_INIT;
      shift_q <= 8'h00;
      bit_cnt <= 4'd0;
    end else if (start) begin
      shift_q <= data;
      bit_cnt <= 4'd8;
      if (clear) crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (busy) begin
      crc     <= (crc >> 1) ^ (feedback ? CRC_POLY : 16'h0000);
      shift_q <= shift_q >> 1;
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: silence-delimited framing, address filter, CRC check,
// frame held in a small RAM for the host until acknowledged.
module modbus_rtu_frame_rx
  import modbus_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_BYTES = 16,
  parameter int BCAST_EN  = 1,
  localparam int LW = $clog2(MAX_BYTES + 1),
  localparam int AW = $clog2(MAX_BYTES)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [7:0]    dev_addr,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [LW-1:0] frame_len,
  output logic          frame_ok,
  output logic [3:0]    frame_err,
  output logic          broadcast,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [2:0]    dbg_state
);

  localparam int T15 = calc_t15(CLK_FREQ, BAUD_RATE);
  localparam int T35 = calc_t35(CLK_FREQ, BAUD_RATE);
  localparam int TW  = $clog2(T35 + 1);
  localparam logic [TW-1:0] T15_C = TW'(T15);
  localparam logic [TW-1:0] T35_C = TW'(T35);

  rx_state_e     state, next_state;
  logic [TW-1:0] timer;
  logic [LW-1:0] count;
  logic [7:0]    addr_byte;
  logic          err_gap, err_ovf;
  logic          wr_en, crc_start, crc_clear, crc_busy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   crc;
  logic          addr_match, room;
  logic [7:0]    mem [2**AW];

  assign addr_match = (addr_byte == dev_addr) || ((BCAST_EN != 0) && (addr_byte == 8'h00));
  assign room       = (count < LW'(MAX_BYTES));

  // Line silence timer: any received byte restarts it regardless of state.
  always_ff @(posedge clk_in) begin
    if (rst_in)             timer <= '0;
    else if (rx_valid)      timer <= '0;
    else if (timer != T35_C) timer <= timer + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    crc_start  = 1'b0;
    crc_clear  = 1'b0;
    wr_addr    = count[AW-1:0];
    case (state)
      ST_INIT:  if (timer == T35_C) next_state = ST_IDLE;
      ST_IDLE: begin
        wr_addr = '0;
        if (rx_valid) begin
          wr_en      = 1'b1;
          crc_clear  = 1'b1;
          crc_start  = 1'b1;
          next_state = ST_RECV;
        end
      end
      ST_RECV: begin
        // UART byte spacing is far longer than the eight-cycle CRC step.
        if (rx_valid) begin
          wr_en     = room;
          crc_start = room;
        end else if (timer == T35_C) begin
          next_state = ST_CHECK;
        end
      end
      ST_CHECK: if (!crc_busy) next_state = addr_match ? ST_HOLD : ST_INIT;
      ST_HOLD:  if (frame_ack) next_state = ST_INIT;
      default:  next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count     <= '0;
      addr_byte <= 8'h00;
      err_gap   <= 1'b0;
      err_ovf   <= 1'b0;
      frame_err <= 4'h0;
      broadcast <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (rx_valid) begin
          count     <= LW'(1);
          addr_byte <= rx_data;
          err_gap   <= 1'b0;
          err_ovf   <= 1'b0;
        end
        ST_RECV: if (rx_valid) begin
          if (timer > T15_C) err_gap <= 1'b1;
          if (room) count   <= count + 1'b1;
          else      err_ovf <= 1'b1;
        end
        ST_CHECK: if (!crc_busy && addr_match) begin
          frame_err[ERR_GAP]   <= err_gap;
          frame_err[ERR_OVF]   <= err_ovf;
          frame_err[ERR_SHORT] <= (count < LW'(4));
          frame_err[ERR_CRC]   <= !err_ovf && (crc != 16'h0000);
          broadcast            <= (addr_byte == 8'h00);
        end
        default: ;
      endcase
      if (state != ST_INIT && next_state == ST_INIT) begin
        count     <= '0;
        frame_err <= 4'h0;
        broadcast <= 1'b0;
      end
    end
  end

  modbus_crc16_byte u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (crc_clear),
    .start  (crc_start),
    .data   (rx_data),
    .busy   (crc_busy),
    .crc    (crc)
  );

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

  assign frame_valid = (state == ST_HOLD);
  assign frame_ok    = (state == ST_HOLD) && (frame_err == 4'h0);
  assign frame_len   = count;
  assign dbg_state   = state;

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for modbus_rtu_frame_rx: frame vector table, scoreboard queue, hold/reset sequences.
module tb_modbus_rtu_frame_rx;

  localparam int CLK_FREQ  = 200000;
  localparam int BAUD_RATE = 115200;
  localparam int MAX_BYTES = 16;
  localparam int T35       = 350;
  localparam int SPACING   = 40;
  localparam int LONG_GAP  = 200;
  localparam int LW        = $clog2(MAX_BYTES + 1);
  localparam int AW        = $clog2(MAX_BYTES);
  localparam int EW        = LW + 6;

  typedef struct packed {
    logic [19:0][7:0] data;
    int               n;
    int               gap_idx;
    logic             want;
    logic [LW-1:0]    len;
    logic [3:0]       err;
    logic             bc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [7:0]    dev_addr = 8'h01;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          frame_valid;
  logic          frame_ack = 1'b0;
  logic [LW-1:0] frame_len;
  logic          frame_ok;
  logic [3:0]    frame_err;
  logic          broadcast;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [2:0]    dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp_bytes [MAX_BYTES];
  vec_t          vecs [7];

  modbus_rtu_frame_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .MAX_BYTES(MAX_BYTES),
    .BCAST_EN (1)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .dev_addr   (dev_addr),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .frame_len  (frame_len),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .broadcast  (broadcast),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference Modbus CRC-16, byte-at-a-time textbook form.
  function automatic logic [15:0] crc_ref(input vec_t v);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < v.n; i++) begin
      c ^= {8'h00, v.data[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [63:0] b, input int n, input bit add_crc, input int gap_idx,
                              input bit want, input int len, input logic [3:0] err, input bit bc);
    vec_t v;
    logic [15:0] c;
    v = '0;
    for (int i = 0; i < n; i++) v.data[i] = b[8*(n-1-i) +: 8];
    v.n = n;
    if (add_crc) begin
      c = crc_ref(v);
      v.data[n]   = c[7:0];
      v.data[n+1] = c[15:8];
      v.n         = n + 2;
    end
    v.gap_idx = gap_idx;
    v.want    = want;
    v.len     = LW'(len);
    v.err     = err;
    v.bc      = bc;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int pre_gap);
    repeat (pre_gap - 1) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input vec_t v, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(v.data[i], (i == v.gap_idx) ? LONG_GAP : SPACING);
  endtask

  task automatic push_expected(input vec_t v);
    exp_q.push_back({v.len, v.err, (v.err == 4'h0), v.bc});
    for (int j = 0; j < MAX_BYTES; j++) exp_bytes[j] = (j < v.n) ? v.data[j] : 8'h00;
  endtask

  task automatic await_frame(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < T35 + 100 && !seen; c++) begin
      if (frame_valid) seen = 1'b1;
      else tick();
    end
  endtask

  // Pops the scoreboard when the DUT presents a frame, then reads the buffer back.
  task automatic collect(input string name, input bit want);
    bit seen;
    logic [EW-1:0] e;
    await_frame(seen);
    if (!want) begin
      check({name, " no_frame"}, {31'd0, seen}, 32'd0);
      return;
    end
    if (!seen) begin
      check({name, " frame_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    check({name, " frame_len"}, 32'(frame_len), 32'(e[EW-1:6]));
    check({name, " frame_err"}, 32'(frame_err), 32'(e[5:2]));
    check({name, " frame_ok"},  32'(frame_ok),  32'(e[1]));
    check({name, " broadcast"}, 32'(broadcast), 32'(e[0]));
    for (int i = 0; i < int'(e[EW-1:6]); i++) begin
      rd_addr = AW'(i);
      tick();
      check($sformatf("%s rd_data[%0d]", name, i), 32'(rd_data), 32'(exp_bytes[i]));
    end
  endtask

  task automatic ack(input string name);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check({name, " released"}, 32'(frame_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " frame_valid"}, 32'(frame_valid), 32'd0);
    check({name, " frame_len"},   32'(frame_len),   32'd0);
    check({name, " frame_err"},   32'(frame_err),   32'd0);
    check({name, " frame_ok"},    32'(frame_ok),    32'd0);
    check({name, " broadcast"},   32'(broadcast),   32'd0);
    check({name, " rd_data"},     32'(rd_data),     32'd0);
    check({name, " state"},       32'(dbg_state),   32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk(64'h010300010001D5CA, 8, 0, -1, 1, 8, 4'b0000, 0);
    vecs[1] = mk(64'h010300010001D5CB, 8, 0, -1, 1, 8, 4'b0001, 0);
    vecs[2] = mk(64'hF0030001_0001C0EB, 8, 0, -1, 0, 0, 4'b0000, 0);
    vecs[3] = vecs[0];
    v = mk(64'h0, 0, 0, 4, 1, 16, 4'b1100, 0);
    for (int i = 0; i < 20; i++) v.data[i] = (i == 0) ? 8'h01 : 8'(8'h10 + i);
    v.n = 20;
    vecs[4] = v;
    vecs[5] = mk(64'h000600010007, 6, 1, -1, 1, 8, 4'b0000, 1);
    vecs[6] = mk(64'h01, 1, 1, -1, 1, 3, 4'b0010, 0);

    rst_in = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_in = 1'b0;
    repeat (T35 + 10) tick();

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].want) push_expected(vecs[k]);
      send_range(vecs[k], 0, vecs[k].n - 1);
      collect($sformatf("vec%0d", k), vecs[k].want);
      if (vecs[k].want && frame_valid) ack($sformatf("vec%0d", k));
      repeat (5) tick();
    end

    // Bytes arriving in HOLD are dropped; ack with a byte restarts the silence wait.
    push_expected(vecs[5]);
    send_range(vecs[5], 0, vecs[5].n - 1);
    collect("hold", 1'b1);
    send_byte(8'hAA, SPACING);
    repeat (3) tick();
    check("hold still_valid", 32'(frame_valid), 32'd1);
    check("hold len_stable",  32'(frame_len),   32'd8);
    rd_addr = '0;
    tick();
    check("hold buf0_kept",   32'(rd_data),     32'h00);
    frame_ack = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h55;
    tick();
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    check("ack_rx released", 32'(frame_valid), 32'd0);
    send_range(vecs[0], 0, vecs[0].n - 1);
    collect("early_frame", 1'b0);
    push_expected(vecs[0]);
    send_range(vecs[0], 0, vecs[0].n - 1);
    collect("after_silence", 1'b1);
    if (frame_valid) ack("after_silence");
    repeat (5) tick();

    // Reset in the middle of a frame discards it and re-arms the T35 wait.
    send_range(vecs[0], 0, 3);
    rst_in = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    tick();
    rst_in = 1'b0;
    send_range(vecs[0], 4, 7);
    collect("post_rst_tail", 1'b0);
    push_expected(vecs[0]);
    send_range(vecs[0], 0, vecs[0].n - 1);
    collect("post_rst_frame", 1'b1);
    if (frame_valid) ack("post_rst_frame");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
